// File: rtl/seq_comp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Holds the FSM state encoding, the 2-bit compare result codes and the
// sizing helpers used to derive the chunk count and chunk-index width.
package seq_comp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CMP_EQ = 2'd0;
    localparam logic [1:0] CMP_LT = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the chunk index; at least one bit even when there is one chunk.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_comp_chunk.sv
// Purely combinational unsigned compare of one CHUNK-bit slice.
// Exactly one of lt_o / eq_o / gt_o is high for any input pair.
module seq_comp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o
);

    // Straight unsigned relational compare of the two slices.
    always_comb begin
        lt_o = (a_i < b_i);
        eq_o = (a_i == b_i);
        gt_o = (a_i > b_i);
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks A and B MSB-first, CHUNK bits per
// cycle, through a single shared chunk comparator. Signed compares are turned
// into unsigned ones by flipping the operand MSBs when they are latched.
//
// Handshake: start is sampled only while busy=0. busy is high from the cycle
// after an accepted start through the done cycle; done is a one-cycle pulse
// and the lt/eq/gt flags are valid from that cycle and held until the next
// done. A start seen while busy is dropped, never queued.
//
// Build option: define SEQ_COMP_EARLY_EXIT_EN to leave RUN on the first
// differing chunk; otherwise every chunk is examined (constant latency).
// dbg_state exposes the FSM state for observation.
module seq_mag_comparator
    import seq_comp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_less_b,
    output logic             a_equal_b,
    output logic             a_greater_b,
    output state_t           dbg_state
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         res_q;
    logic [1:0]         res_d;
    logic               lt_q;
    logic               eq_q;
    logic               gt_q;

    logic [WIDTH-1:0]   msb_mask;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic               c_lt;
    logic               c_eq;
    logic               c_gt;
    logic [1:0]         chunk_code;
    logic               last_chunk;

    // Offset-binary mask: in signed mode only the operand MSB is inverted.
    always_comb begin
        msb_mask = '0;
        msb_mask[WIDTH-1] = signed_mode;
    end

    // Select the chunk under inspection by shifting it down to bit 0.
    always_comb begin
        a_chunk = CHUNK'(a_q >> (int'(idx_q) * CHUNK));
        b_chunk = CHUNK'(b_q >> (int'(idx_q) * CHUNK));
    end

    seq_comp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i  (a_chunk),
        .b_i  (b_chunk),
        .lt_o (c_lt),
        .eq_o (c_eq),
        .gt_o (c_gt)
    );

    // Keep the first recorded difference; later chunks only matter while equal.
    always_comb begin
        case ({c_lt, c_eq, c_gt})
            3'b100:  chunk_code = CMP_LT;
            3'b001:  chunk_code = CMP_GT;
            default: chunk_code = CMP_EQ;
        endcase
        res_d = (res_q == CMP_EQ) ? chunk_code : res_q;
`ifdef SEQ_COMP_EARLY_EXIT_EN
        last_chunk = (idx_q == '0) || (chunk_code != CMP_EQ);
`else
        last_chunk = (idx_q == '0);
`endif
    end

    // Control FSM plus operand, index and result-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            res_q   <= CMP_EQ;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a ^ msb_mask;
                        b_q     <= b ^ msb_mask;
                        idx_q   <= IDX_W'(NCHUNK - 1);
                        res_q   <= CMP_EQ;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q <= res_d;
                    if (last_chunk) begin
                        // Flags become visible in the DONE cycle.
                        lt_q    <= (res_d == CMP_LT);
                        eq_q    <= (res_d == CMP_EQ);
                        gt_q    <= (res_d == CMP_GT);
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign a_less_b    = lt_q;
    assign a_equal_b   = eq_q;
    assign a_greater_b = gt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: a WIDTH=16/CHUNK=4 instance and a
// WIDTH=16/CHUNK=16 instance, directed cases plus randomized transactions
// checked against an arithmetic reference model.
module tb_seq_mag_comparator;
    import seq_comp_pkg::*;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start0, sm0, busy0, done0, lt0, eq0, gt0;
    logic [W-1:0] a0, b0;
    state_t       st0;
    logic         start1, sm1, busy1, done1, lt1, eq1, gt1;
    logic [W-1:0] a1, b1;
    state_t       st1;

    seq_mag_comparator #(.WIDTH(W), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .signed_mode(sm0),
        .a(a0), .b(b0), .busy(busy0), .done(done0),
        .a_less_b(lt0), .a_equal_b(eq0), .a_greater_b(gt0), .dbg_state(st0)
    );

    seq_mag_comparator #(.WIDTH(W), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1),
        .a(a1), .b(b1), .busy(busy1), .done(done1),
        .a_less_b(lt1), .a_equal_b(eq1), .a_greater_b(gt1), .dbg_state(st1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] last_f [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Flags as {lt, eq, gt} from plain integer comparison.
    function automatic logic [2:0] model_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sm);
        int va, vb;
        va = sm ? int'($signed(a)) : int'(a);
        vb = sm ? int'($signed(b)) : int'(b);
        if (va < vb) return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    // Number of chunks examined before the result is final.
    function automatic int model_k(input logic [W-1:0] a, input logic [W-1:0] b, input int chunk);
        int nch;
        nch = W / chunk;
`ifdef SEQ_COMP_EARLY_EXIT_EN
        for (int p = 1; p <= nch; p++) begin
            int sh;
            sh = W - p * chunk;
            if (((a >> sh) & ((1 << chunk) - 1)) != ((b >> sh) & ((1 << chunk) - 1)))
                return p;
        end
`endif
        return nch;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm);
        if (sel == 0) begin
            start0 = s; a0 = a; b0 = b; sm0 = sm;
        end else begin
            start1 = s; a1 = a; b1 = b; sm1 = sm;
        end
    endtask

    task automatic sample(input int sel, output logic bsy, output logic dn, output logic [2:0] flg);
        if (sel == 0) begin
            bsy = busy0; dn = done0; flg = {lt0, eq0, gt0};
        end else begin
            bsy = busy1; dn = done1; flg = {lt1, eq1, gt1};
        end
    endtask

    // Issue one transaction (caller is at a negedge in an IDLE cycle) and
    // follow it through done. poke=1 keeps hammering start while busy.
    task automatic run_txn(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sm, input bit poke);
        int chunk, exp_k, done_cyc;
        logic [2:0] exp_f, flg;
        logic bsy, dn;
        chunk    = (sel == 0) ? 4 : 16;
        exp_k    = model_k(a, b, chunk);
        exp_f    = model_flags(a, b, sm);
        done_cyc = -1;
        sample(sel, bsy, dn, flg);
        check("busy_before_start", 32'(bsy), 32'd0);
        drive(sel, 1'b1, a, b, sm);
        @(negedge clk);
        // Operand changes after acceptance must not matter.
        drive(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (poke)
                drive(sel, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            sample(sel, bsy, dn, flg);
            check("busy_while_active", 32'(bsy), 32'd1);
            if (dn) begin
                done_cyc = cyc;
                break;
            end
            check("flags_held_during_run", 32'(flg), 32'(last_f[sel]));
            @(negedge clk);
        end
        check("done_cycle", done_cyc, exp_k + 1);
        check("result_flags", 32'(flg), 32'(exp_f));
        last_f[sel] = exp_f;
        @(negedge clk);
        drive(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        sample(sel, bsy, dn, flg);
        check("done_single_pulse", 32'(dn), 32'd0);
        check("idle_after_done", 32'(bsy), 32'd0);
        check("flags_after_done", 32'(flg), 32'(exp_f));
    endtask

    task automatic idle_hold(input int sel, input int n);
        logic bsy, dn;
        logic [2:0] flg;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample(sel, bsy, dn, flg);
            check("idle_no_done", 32'(dn), 32'd0);
            check("flags_hold_idle", 32'(flg), 32'(last_f[sel]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ra, rb;
        logic bsy, dn;
        logic [2:0] flg;
        rst = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        last_f[0] = 3'b000;
        last_f[1] = 3'b000;
        #12;
        check("reset_busy0", 32'(busy0), 32'd0);
        check("reset_done0", 32'(done0), 32'd0);
        check("reset_flags0", 32'({lt0, eq0, gt0}), 32'd0);
        check("reset_state0", 32'(st0), 32'(S_IDLE));
        check("reset_flags1", 32'({lt1, eq1, gt1}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, CHUNK=4.
        run_txn(0, 16'h1234, 16'h1234, 1'b0, 1'b0);
        run_txn(0, 16'h8000, 16'h7FFF, 1'b0, 1'b0);
        run_txn(0, 16'h8000, 16'h0001, 1'b1, 1'b0);
        run_txn(0, 16'h8000, 16'h0001, 1'b0, 1'b0);
        run_txn(0, 16'h00A0, 16'h00A1, 1'b0, 1'b1);
        idle_hold(0, 3);

        // Reset in cycle 2 of a transaction aborts it with no done.
        drive(0, 1'b1, 16'h1234, 16'h1200, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_abort_busy", 32'(busy0), 32'd0);
        check("rst_abort_done", 32'(done0), 32'd0);
        check("rst_abort_flags", 32'({lt0, eq0, gt0}), 32'd0);
        check("rst_abort_state", 32'(st0), 32'(S_IDLE));
        last_f[0] = 3'b000;
        last_f[1] = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        idle_hold(0, 6);
        run_txn(0, 16'hF00D, 16'hF00E, 1'b1, 1'b0);

        // Full-width chunk instance.
        run_txn(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        idle_hold(1, 5);
        run_txn(1, 16'hFFFF, 16'h0000, 1'b0, 1'b1);

        // Randomized transactions.
        for (int t = 0; t < 30; t++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom);
                1: rb = ra;
                2: rb = ra ^ (16'd1 << $urandom_range(0, 15));
                default: rb = (ra & 16'hFF00) | 16'($urandom_range(0, 255));
            endcase
            run_txn(0, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int t = 0; t < 8; t++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            run_txn(1, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        sample(0, bsy, dn, flg);
        check("final_idle0", 32'(bsy), 32'd0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Multi-cycle magnitude comparator for wide operands. It processes A and B MSB-first, CHUNK bits per cycle.
- Supports unsigned or two's-complement compare, selected per transaction.
- Start/busy/done handshake, so wide compares do not form a long combinational path.
- Result flags are registered and held until the next transaction. Used as the shared compare engine in datapaths that sort or threshold wide words.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam (number of chunks), not overridable.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; latched with start
- a  in  WIDTH  operand A; latched with start
- b  in  WIDTH  operand B; latched with start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse; result flags valid from this cycle
- a_less_b  out  1  registered result
- a_equal_b  out  1  registered result
- a_greater_b  out  1  registered result

Behaviour:
- Reset (async, rst=1) gives:
  - state=IDLE, busy=0, done=0.
  - a_less_b=0, a_equal_b=0, a_greater_b=0.
  - Internal operand registers and chunk index cleared.
- Reset mid-transaction aborts it immediately. No done pulse is issued afterwards.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b and signed_mode, sets idx=NCHUNK-1, goes to RUN.
  - In signed mode, the MSB of both latched operands is inverted (offset-binary). All chunk compares are then unsigned.
- RUN, each cycle:
  - Compare chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) of A vs B.
  - If the chunks differ and no difference has yet been recorded, record lt/gt.
  - Go to DONE when idx==0, or per the Optional Feature. Otherwise decrement idx.
- DONE:
  - Lasts one cycle; done=1.
  - Flags load: exactly one of lt/eq/gt is set. eq only if no chunk differed.
  - Then go to IDLE.
- Flags hold their value through IDLE until the next DONE. They are not cleared on a new start.
- busy = (state != IDLE). done = (state == DONE).
- start while busy=1 (including the DONE cycle) is ignored. There is no queuing.
- Operand/mode input changes after acceptance have no effect.
- Latency, start sampled at cycle 0:
  - k = number of chunks examined.
  - RUN occupies cycles 1..k; done is at cycle k+1.
  - Back-to-back: the next start is accepted at cycle k+2, i.e. the first IDLE cycle.
- CHUNK=WIDTH is legal: k=1, latency 2.

Optional Feature:
- Macro: SEQ_COMP_EARLY_EXIT_EN.
- Defined: RUN exits to DONE on the first differing chunk. k = position of the first differing chunk counted from the MSB, 1..NCHUNK; equal operands give k=NCHUNK.
- Undefined: RUN always examines all NCHUNK chunks. The first recorded difference decides the result, so latency is constant (k=NCHUNK, done at cycle NCHUNK+1).
- Flag values are identical either way; only timing differs.

Decomposition:
- Package seq_comp_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - result-code constants (CMP_LT, CMP_EQ, CMP_GT, 2-bit);
  - a function computing NCHUNK and the idx width via clog2.
- Sub-module seq_comp_chunk:
  - Purely combinational CHUNK-bit unsigned compare producing lt/eq/gt.
  - Instantiated once and fed by an idx-selected slice.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Unsigned, a=0x1234, b=0x1234 -> done at cycle 5, a_equal_b=1, busy high cycles 1..5.
- Unsigned, a=0x8000, b=0x7FFF:
  - a_greater_b=1.
  - With SEQ_COMP_EARLY_EXIT_EN: done at cycle 2.
  - Without: done at cycle 5.
- Signed, a=0x8000 (-32768), b=0x0001 -> a_less_b=1. Same operands unsigned -> a_greater_b=1.
- Unsigned, a=0x00A0, b=0x00A1 (differ only in last chunk) -> a_less_b=1, done at cycle 5 in both builds. Re-issue start while busy -> ignored, single done pulse.
- Assert rst at cycle 2 of a transaction:
  - All outputs 0 immediately, no done.
  - A new start after rst deasserts -> normal result.
- CHUNK=16, a=0xFFFF, b=0x0000 signed -> done at cycle 2, a_less_b=1. Flags hold until the next done.
